// File: rtl/otter_exec_unit.sv
// otter_exec_unit: execute-stage core of the pipelined OTTER RV32I CPU.
// Combines the ALU, the branch address generator and the branch condition
// generator. Everything is combinational except one registered copy of the
// ALU result (RESULT_Q), which feeds the EX/MEM boundary and forwarding.
// There is no FSM and no handshake in this block: the outputs follow the
// inputs every cycle, and the stage register is gated only by EN/CLR/RST.
module otter_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic            CLR,
    input  logic [3:0]      ALU_FUN,
    input  logic [XLEN-1:0] SRC_A,
    input  logic [XLEN-1:0] SRC_B,
    input  logic [XLEN-1:0] RS1,
    input  logic [XLEN-1:0] RS2,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] I_TYPE,
    input  logic [XLEN-1:0] J_TYPE,
    input  logic [XLEN-1:0] B_TYPE,
    output logic [XLEN-1:0] RESULT,
    output logic [XLEN-1:0] RESULT_Q,
    output logic [XLEN-1:0] JAL,
    output logic [XLEN-1:0] JALR,
    output logic [XLEN-1:0] BRANCH,
    output logic            BR_EQ,
    output logic            BR_LT,
    output logic            BR_LTU
);

    // ALU operation codes
    localparam logic [3:0] FUN_ADD  = 4'b0000;
    localparam logic [3:0] FUN_SUB  = 4'b1000;
    localparam logic [3:0] FUN_SLL  = 4'b0001;
    localparam logic [3:0] FUN_SLT  = 4'b0010;
    localparam logic [3:0] FUN_SLTU = 4'b0011;
    localparam logic [3:0] FUN_XOR  = 4'b0100;
    localparam logic [3:0] FUN_SRL  = 4'b0101;
    localparam logic [3:0] FUN_OR   = 4'b0110;
    localparam logic [3:0] FUN_AND  = 4'b0111;
    localparam logic [3:0] FUN_SRA  = 4'b1101;
    localparam logic [3:0] FUN_LUI  = 4'b1001;

    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_d;
    logic [XLEN-1:0] result_d;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] jalr_sum;

    assign shamt = SRC_B[4:0];

    // ALU: select the operation result; unused codes give zero
    always_comb begin
        alu_d = '0;
        case (ALU_FUN)
            FUN_ADD:  alu_d = SRC_A + SRC_B;
            FUN_SUB:  alu_d = SRC_A - SRC_B;
            FUN_SLL:  alu_d = SRC_A << shamt;
            FUN_SLT:  alu_d = ($signed(SRC_A) < $signed(SRC_B)) ? {{(XLEN-1){1'b0}}, 1'b1} : '0;
            FUN_SLTU: alu_d = (SRC_A < SRC_B) ? {{(XLEN-1){1'b0}}, 1'b1} : '0;
            FUN_XOR:  alu_d = SRC_A ^ SRC_B;
            FUN_SRL:  alu_d = SRC_A >> shamt;
            FUN_OR:   alu_d = SRC_A | SRC_B;
            FUN_AND:  alu_d = SRC_A & SRC_B;
            FUN_SRA:  alu_d = $unsigned($signed(SRC_A) >>> shamt);
            FUN_LUI:  alu_d = SRC_A;
            default:  alu_d = '0;
        endcase
    end

    assign RESULT = alu_d;

    // Branch address generator: modulo-2^32 target sums; JALR drops bit 0 only
    assign jalr_sum = RS1 + I_TYPE;
    assign JAL      = PC + J_TYPE;
    assign BRANCH   = PC + B_TYPE;
    assign JALR     = {jalr_sum[XLEN-1:1], 1'b0};

    // Branch condition generator
    assign BR_EQ  = (RS1 == RS2);
    assign BR_LT  = ($signed(RS1) < $signed(RS2));
    assign BR_LTU = (RS1 < RS2);

    // Stage register next value: reset beats bubble clear beats load beats hold
    always_comb begin
        result_d = result_q;
        if (RST) begin
            result_d = '0;
        end else if (CLR) begin
            result_d = '0;
        end else if (EN) begin
            result_d = alu_d;
        end
    end

    // Stage register update
    always_ff @(posedge CLK) begin
        result_q <= result_d;
    end

    assign RESULT_Q = result_q;

endmodule

// File: tb/tb_otter_exec_unit.sv
// tb_otter_exec_unit: directed-vector bench for the OTTER execute unit.
module tb_otter_exec_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic        clr;
    logic [3:0]  alu_fun;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] i_type;
    logic [31:0] j_type;
    logic [31:0] b_type;
    logic [31:0] result;
    logic [31:0] result_q;
    logic [31:0] jal;
    logic [31:0] jalr;
    logic [31:0] branch;
    logic        br_eq;
    logic        br_lt;
    logic        br_ltu;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    otter_exec_unit dut (
        .CLK      (clk),
        .RST      (rst),
        .EN       (en),
        .CLR      (clr),
        .ALU_FUN  (alu_fun),
        .SRC_A    (src_a),
        .SRC_B    (src_b),
        .RS1      (rs1),
        .RS2      (rs2),
        .PC       (pc),
        .I_TYPE   (i_type),
        .J_TYPE   (j_type),
        .B_TYPE   (b_type),
        .RESULT   (result),
        .RESULT_Q (result_q),
        .JAL      (jal),
        .JALR     (jalr),
        .BRANCH   (branch),
        .BR_EQ    (br_eq),
        .BR_LT    (br_lt),
        .BR_LTU   (br_ltu)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // driver: apply ALU operands, settle, compare the combinational result
    task automatic alu_vec(input string tag, input logic [3:0] fun,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        alu_fun = fun;
        src_a   = a;
        src_b   = b;
        #1;
        check_val(tag, result, exp);
    endtask

    // driver: one clocked step of the stage register, checked via exp_q
    task automatic reg_step(input string tag, input logic r, input logic e,
                            input logic c, input logic [31:0] a,
                            input logic [31:0] exp);
        rst     = r;
        en      = e;
        clr     = c;
        alu_fun = 4'b0000;
        src_a   = a;
        src_b   = 32'h0;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check_val(tag, result_q, exp_q.pop_front());
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0;
        alu_fun = 4'b0; src_a = '0; src_b = '0;
        rs1 = '0; rs2 = '0; pc = '0;
        i_type = '0; j_type = '0; b_type = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_result_q", result_q, 32'h0);
        rst = 1'b0;

        // ALU vectors
        alu_vec("add_ovf",   4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000);
        alu_vec("add",       4'b0000, 32'h00001234, 32'h00000F0F, 32'h00002143);
        alu_vec("sub_wrap",  4'b1000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF);
        alu_vec("slt",       4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001);
        alu_vec("sltu",      4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
        alu_vec("sra",       4'b1101, 32'h80000000, 32'h00000024, 32'hF8000000);
        alu_vec("srl",       4'b0101, 32'h80000000, 32'h00000024, 32'h08000000);
        alu_vec("sll",       4'b0001, 32'h00000001, 32'h0000001F, 32'h80000000);
        alu_vec("lui",       4'b1001, 32'h12345000, 32'hDEADBEEF, 32'h12345000);
        alu_vec("xor",       4'b0100, 32'hF0F0FF00, 32'h0FF0F0F0, 32'hFF000FF0);
        alu_vec("or",        4'b0110, 32'hF0F0FF00, 32'h0FF0F0F0, 32'hFFF0FFF0);
        alu_vec("and",       4'b0111, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000);
        alu_vec("undef_fun", 4'b1111, 32'h12345678, 32'h87654321, 32'h00000000);

        // branch address generator
        pc = 32'h100; j_type = 32'hFFFFFFF0; b_type = 32'h8;
        rs1 = 32'h201; i_type = 32'h2;
        #1;
        check_val("jal",    jal,    32'h000000F0);
        check_val("branch", branch, 32'h00000108);
        check_val("jalr",   jalr,   32'h00000202);
        rs1 = 32'hFFFFFFFF; i_type = 32'h2;
        #1;
        check_val("jalr_wrap", jalr, 32'h00000000);

        // branch condition generator
        rs1 = 32'hFFFFFFFF; rs2 = 32'h1;
        #1;
        check_val("bcg_neg_eq",  {31'b0, br_eq},  32'h0);
        check_val("bcg_neg_lt",  {31'b0, br_lt},  32'h1);
        check_val("bcg_neg_ltu", {31'b0, br_ltu}, 32'h0);
        rs1 = 32'h5; rs2 = 32'h5;
        #1;
        check_val("bcg_same_eq",  {31'b0, br_eq},  32'h1);
        check_val("bcg_same_lt",  {31'b0, br_lt},  32'h0);
        check_val("bcg_same_ltu", {31'b0, br_ltu}, 32'h0);

        // stage register: load, stall, clear, priorities
        @(posedge clk);
        #1;
        reg_step("rq_load",     1'b0, 1'b1, 1'b0, 32'hAA, 32'hAA);
        reg_step("rq_stall",    1'b0, 1'b0, 1'b0, 32'hBB, 32'hAA);
        reg_step("rq_clr",      1'b0, 1'b0, 1'b1, 32'hBB, 32'h00);
        reg_step("rq_reload",   1'b0, 1'b1, 1'b0, 32'hAA, 32'hAA);
        reg_step("rq_clr_en",   1'b0, 1'b1, 1'b1, 32'hCC, 32'h00);
        reg_step("rq_reload2",  1'b0, 1'b1, 1'b0, 32'hDD, 32'hDD);
        reg_step("rq_rst_en",   1'b1, 1'b1, 1'b0, 32'hCC, 32'h00);
        reg_step("rq_post_rst", 1'b0, 1'b0, 1'b0, 32'hCC, 32'h00);
        reg_step("rq_next_en",  1'b0, 1'b1, 1'b0, 32'hCC, 32'hCC);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
